// File: rtl/wb_b3_pkg.sv
// Shared Wishbone B3 burst encodings (CTI/BTE) and the burst-length to BTE mapping.
// Latency: none; constants and pure functions only.
// Backpressure: not applicable.
package wb_b3_pkg;

  // Cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Burst type extensions
  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  // Wrap size follows the line length; anything unsupported degrades to linear.
  function automatic logic [1:0] bte_for_len(input int unsigned len);
    logic [1:0] bte;
    case (len)
      4:       bte = BTE_WRAP4;
      8:       bte = BTE_WRAP8;
      16:      bte = BTE_WRAP16;
      default: bte = BTE_LINEAR;
    endcase
    return bte;
  endfunction

endpackage

// File: rtl/wb_b3_wrap_adr.sv
// Next word address inside a Wishbone B3 burst, wrapping within the aligned block chosen by BTE.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to advance.
module wb_b3_wrap_adr
  import wb_b3_pkg::*;
#(
  parameter int aw = 32
) (
  input  logic [aw-1:0] adr_i,
  input  logic [1:0]    bte_i,
  output logic [aw-1:0] nxt_adr_o
);

  localparam logic [aw-3:0] WORD_ONE = {{(aw-3){1'b0}}, 1'b1};

  // Only the word bits inside the wrap block move; upper bits hold, byte bits stay zero.
  always_comb begin
    nxt_adr_o = adr_i;
    case (bte_i)
      BTE_WRAP4:  nxt_adr_o[3:2]    = adr_i[3:2] + 2'd1;
      BTE_WRAP8:  nxt_adr_o[4:2]    = adr_i[4:2] + 3'd1;
      BTE_WRAP16: nxt_adr_o[5:2]    = adr_i[5:2] + 4'd1;
      default:    nxt_adr_o[aw-1:2] = adr_i[aw-1:2] + WORD_ONE;
    endcase
    nxt_adr_o[1:0] = 2'b00;
  end

endmodule

// File: rtl/wb_b3_line_master.sv
// Turns one cache-line request into a critical-word-first Wishbone B3 wrap burst (refill or write-back).
// Latency: bus cycle starts the cycle after accept; next address/CTI one cycle after each ack; done/err one cycle after the final ack/err.
// Backpressure: req_ready_o only while idle; beats advance on wb_ack_i, wb_rty_i inserts a one-cycle bus release.
module wb_b3_line_master
  import wb_b3_pkg::*;
#(
  parameter int dw        = 32,
  parameter int aw        = 32,
  parameter int burst_len = 4
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [aw-1:0] req_adr_i,
  input  logic          req_we_i,
  input  logic [dw-1:0] wdat_i,
  output logic          wdat_rd_o,
  output logic [dw-1:0] rdat_o,
  output logic          rdat_valid_o,
  output logic          done_o,
  output logic          err_o,
  output logic [aw-1:0] wb_adr_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [3:0]    wb_sel_o,
  output logic [dw-1:0] wb_dat_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i,
  input  logic [dw-1:0] wb_dat_i
);

  localparam int BW = $clog2(burst_len);
  localparam logic [BW-1:0] LAST_BEAT = BW'(burst_len - 1);
  localparam logic [1:0]    LINE_BTE  = bte_for_len(burst_len);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [aw-1:0] adr_q, adr_d, nxt_adr;
  logic [BW-1:0] beat_q, beat_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic [2:0]    cti_q, cti_d;
  logic [1:0]    bte_q, bte_d;
  logic [3:0]    sel_q, sel_d;
  logic [dw-1:0] rdat_q, rdat_d;
  logic          rdat_vld_q, rdat_vld_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          go_idle;
  logic          unused_adr_lsb;

  // Byte offset of the critical word is irrelevant: transfers are whole words.
  assign unused_adr_lsb = ^req_adr_i[1:0];

  function automatic logic [2:0] beat_cti(input logic [BW-1:0] beat);
    return (beat == LAST_BEAT) ? CTI_EOB : CTI_INCR;
  endfunction

  wb_b3_wrap_adr #(.aw(aw)) u_wrap_adr (
    .adr_i     (adr_q),
    .bte_i     (bte_q),
    .nxt_adr_o (nxt_adr)
  );

  // Burst sequencing: accept, advance on ack, abort on err, back off one cycle on rty.
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    beat_d     = beat_q;
    we_d       = we_q;
    cyc_d      = cyc_q;
    cti_d      = cti_q;
    bte_d      = bte_q;
    sel_d      = sel_q;
    rdat_d     = rdat_q;
    rdat_vld_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    go_idle    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d = S_BURST;
          adr_d   = {req_adr_i[aw-1:2], 2'b00};
          we_d    = req_we_i;
          beat_d  = '0;
          cyc_d   = 1'b1;
          cti_d   = beat_cti('0);
          bte_d   = LINE_BTE;
          sel_d   = 4'hf;
        end
      end
      S_BURST: begin
        if (wb_err_i) begin
          // Error beats are not counted and never complete the line.
          err_d   = 1'b1;
          go_idle = 1'b1;
        end else if (wb_ack_i) begin
          if (!we_q) begin
            rdat_d     = wb_dat_i;
            rdat_vld_d = 1'b1;
          end
          if (beat_q == LAST_BEAT) begin
            done_d  = 1'b1;
            go_idle = 1'b1;
          end else begin
            adr_d  = nxt_adr;
            beat_d = beat_q + BW'(1);
            cti_d  = beat_cti(beat_q + BW'(1));
          end
        end else if (wb_rty_i) begin
          state_d = S_HOLD;
          cyc_d   = 1'b0;
        end
      end
      S_HOLD: begin
        // Reissue the same beat; address is untouched.
        state_d = S_BURST;
        cyc_d   = 1'b1;
        cti_d   = beat_cti(beat_q);
      end
      default: go_idle = 1'b1;
    endcase
    if (go_idle) begin
      state_d = S_IDLE;
      cyc_d   = 1'b0;
      we_d    = 1'b0;
      cti_d   = CTI_CLASSIC;
      bte_d   = BTE_LINEAR;
      sel_d   = 4'h0;
    end
  end

  // State and registered bus/client outputs, cleared by synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      adr_q      <= '0;
      beat_q     <= '0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      cti_q      <= CTI_CLASSIC;
      bte_q      <= BTE_LINEAR;
      sel_q      <= 4'h0;
      rdat_q     <= '0;
      rdat_vld_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      beat_q     <= beat_d;
      we_q       <= we_d;
      cyc_q      <= cyc_d;
      cti_q      <= cti_d;
      bte_q      <= bte_d;
      sel_q      <= sel_d;
      rdat_q     <= rdat_d;
      rdat_vld_q <= rdat_vld_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign wdat_rd_o    = (state_q == S_BURST) & we_q & wb_ack_i & ~wb_err_i;
  assign rdat_o       = rdat_q;
  assign rdat_valid_o = rdat_vld_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign wb_adr_o     = adr_q;
  assign wb_cti_o     = cti_q;
  assign wb_bte_o     = bte_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_we_o      = we_q;
  assign wb_sel_o     = sel_q;
  assign wb_dat_o     = wdat_i;

endmodule

// File: tb/tb_wb_b3_line_master.sv
// Directed bench: two masters (4- and 8-beat lines) share one behavioural RAM slave that acks every strobed cycle.
// Latency: slave responds in the same cycle the strobe is seen.
// Backpressure: slave injects err/rty on chosen beats; request valid is held while work is pending.
module tb_wb_b3_line_master;

  logic wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  logic        wb_rst_i, use8, req_vld4, req_vld8, req_we, ack, err, rty;
  logic [31:0] req_adr, wdat, sdat;

  logic        rdy4, rdy8, wrd4, wrd8, rv4, rv8, dn4, dn8, er4, er8;
  logic        cyc4, cyc8, stb4, stb8, we4, we8;
  logic [31:0] rdat4, rdat8, adr4, adr8, dato4, dato8;
  logic [2:0]  cti4, cti8;
  logic [1:0]  bte4, bte8;
  logic [3:0]  sel4, sel8;

  wb_b3_line_master #(.dw(32), .aw(32), .burst_len(4)) u_dut4 (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .req_valid_i(req_vld4), .req_ready_o(rdy4), .req_adr_i(req_adr), .req_we_i(req_we),
    .wdat_i(wdat), .wdat_rd_o(wrd4), .rdat_o(rdat4), .rdat_valid_o(rv4),
    .done_o(dn4), .err_o(er4),
    .wb_adr_o(adr4), .wb_cti_o(cti4), .wb_bte_o(bte4), .wb_cyc_o(cyc4), .wb_stb_o(stb4),
    .wb_we_o(we4), .wb_sel_o(sel4), .wb_dat_o(dato4),
    .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty), .wb_dat_i(sdat)
  );

  wb_b3_line_master #(.dw(32), .aw(32), .burst_len(8)) u_dut8 (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .req_valid_i(req_vld8), .req_ready_o(rdy8), .req_adr_i(req_adr), .req_we_i(req_we),
    .wdat_i(wdat), .wdat_rd_o(wrd8), .rdat_o(rdat8), .rdat_valid_o(rv8),
    .done_o(dn8), .err_o(er8),
    .wb_adr_o(adr8), .wb_cti_o(cti8), .wb_bte_o(bte8), .wb_cyc_o(cyc8), .wb_stb_o(stb8),
    .wb_we_o(we8), .wb_sel_o(sel8), .wb_dat_o(dato8),
    .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty), .wb_dat_i(sdat)
  );

  // Selected master as seen by the slave model
  logic        m_rdy, m_wrd, m_rv, m_done, m_err, m_cyc, m_stb, m_we;
  logic [31:0] m_rdat, m_adr, m_dato;
  logic [2:0]  m_cti;
  logic [1:0]  m_bte;
  logic [3:0]  m_sel;
  assign m_rdy  = use8 ? rdy8  : rdy4;
  assign m_wrd  = use8 ? wrd8  : wrd4;
  assign m_rv   = use8 ? rv8   : rv4;
  assign m_done = use8 ? dn8   : dn4;
  assign m_err  = use8 ? er8   : er4;
  assign m_cyc  = use8 ? cyc8  : cyc4;
  assign m_stb  = use8 ? stb8  : stb4;
  assign m_we   = use8 ? we8   : we4;
  assign m_rdat = use8 ? rdat8 : rdat4;
  assign m_adr  = use8 ? adr8  : adr4;
  assign m_dato = use8 ? dato8 : dato4;
  assign m_cti  = use8 ? cti8  : cti4;
  assign m_bte  = use8 ? bte8  : bte4;
  assign m_sel  = use8 ? sel8  : sel4;

  logic [31:0] mem [0:255];
  int checks = 0;
  int errors = 0;
  int cyc_n, acks, first_ack, acc_cyc, done_n, done_cyc, err_n, err_seen_cyc, err_drv_cyc;
  int last_rv_cyc, pops, widx, pend, err_beat, rty_beat, rty_used;
  logic [31:0] adr_log[$];
  logic [2:0]  cti_log[$];
  logic [31:0] rd_log[$];
  bit          cyc_hist[$];
  logic [31:0] rty_adr;
  logic [1:0]  bte_seen;
  logic [3:0]  sel_seen;

  logic [31:0] exp_a [4] = '{32'h8, 32'hC, 32'h0, 32'h4};
  logic [31:0] exp_b [8] = '{32'h114, 32'h118, 32'h11C, 32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " ctl"}, {24'd0, m_rdy, m_cyc, m_stb, m_we, m_rv, m_done, m_err, m_wrd}, 32'h80);
    check({tag, " cti_bte_sel"}, {23'd0, m_cti, m_bte, m_sel}, 32'h0);
    check({tag, " adr"}, m_adr, 32'h0);
    check({tag, " rdat"}, m_rdat, 32'h0);
  endtask

  task automatic clear_rec();
    adr_log.delete(); cti_log.delete(); rd_log.delete(); cyc_hist.delete();
    cyc_n = 0; acks = 0; first_ack = -1; acc_cyc = -1; done_n = 0; done_cyc = -1;
    err_n = 0; err_seen_cyc = -1; err_drv_cyc = -1; last_rv_cyc = -1; pops = 0; widx = 0;
    err_beat = -1; rty_beat = -1; rty_used = 0; rty_adr = '0;
    wdat = 32'hA0;
  endtask

  // Number of cycles with cyc low between the first and last cyc-high cycle
  function automatic int gaps();
    int first = -1;
    int last = -1;
    int n = 0;
    foreach (cyc_hist[i]) if (cyc_hist[i]) begin
      if (first < 0) first = i;
      last = i;
    end
    if (first >= 0) for (int i = first; i < last; i++) if (!cyc_hist[i]) n++;
    return n;
  endfunction

  // One clock: observe at the falling edge, then drive request and slave response for this cycle
  task automatic tick();
    bit req_on;
    @(negedge wb_clk_i);
    cyc_hist.push_back(m_cyc);
    if (m_rv) begin rd_log.push_back(m_rdat); last_rv_cyc = cyc_n; end
    if (m_done) begin done_n++; done_cyc = cyc_n; end
    if (m_err) begin err_n++; err_seen_cyc = cyc_n; end
    req_on = (pend > 0);
    req_vld4 = req_on & ~use8;
    req_vld8 = req_on & use8;
    if (req_on && m_rdy) begin pend--; acc_cyc = cyc_n; end
    ack = 1'b0; err = 1'b0; rty = 1'b0; sdat = '0;
    if (m_cyc && m_stb) begin
      if (acks == err_beat) begin
        err = 1'b1; err_drv_cyc = cyc_n;
      end else if (acks == rty_beat && rty_used == 0) begin
        rty = 1'b1; rty_used = 1; rty_adr = m_adr;
      end else begin
        ack = 1'b1;
        adr_log.push_back(m_adr);
        cti_log.push_back(m_cti);
        if (acks == 0) begin first_ack = cyc_n; bte_seen = m_bte; sel_seen = m_sel; end
        if (m_we) mem[m_adr[9:2]] = m_dato;
        else sdat = mem[m_adr[9:2]];
        acks++;
      end
    end
    #1;
    if (m_wrd) begin pops++; widx++; end
    wdat = 32'hA0 + 32'(widx);
    cyc_n++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    wb_rst_i = 1'b1; use8 = 1'b0; req_vld4 = 1'b0; req_vld8 = 1'b0;
    req_adr = '0; req_we = 1'b0; ack = 1'b0; err = 1'b0; rty = 1'b0; sdat = '0; pend = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hD000_0000 | 32'(i);
    clear_rec();

    // Reset state, during and after reset
    repeat (2) @(negedge wb_clk_i);
    check_reset("rst_hold");
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check_reset("rst_rel");
    check("rst dut8 ready/cyc", {30'd0, rdy8, cyc8}, 32'h2);

    // A: 4-beat refill, critical word 2
    clear_rec(); use8 = 1'b0; req_adr = 32'h8; req_we = 1'b0; pend = 1;
    repeat (12) tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("A adr%0d", i), adr_log[i], exp_a[i]);
      check($sformatf("A cti%0d", i), {29'd0, cti_log[i]}, (i == 3) ? 32'h7 : 32'h2);
      check($sformatf("A rdat%0d", i), rd_log[i], 32'hD000_0000 | (exp_a[i] >> 2));
    end
    check("A bte", {30'd0, bte_seen}, 32'h1);
    check("A sel", {28'd0, sel_seen}, 32'hf);
    check("A accept->first ack", first_ack - acc_cyc, 1);
    check("A rdat count", rd_log.size(), 4);
    check("A done count", done_n, 1);
    check("A done after first ack", done_cyc - first_ack, 4);
    check("A done with last rdat", done_cyc, last_rv_cyc);

    // B: 8-beat write-back from 0x114, data A0..A7
    clear_rec(); use8 = 1'b1; req_adr = 32'h114; req_we = 1'b1; pend = 1;
    repeat (16) tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("B adr%0d", i), adr_log[i], exp_b[i]);
      check($sformatf("B ram%0d", i), mem[exp_b[i][9:2]], 32'hA0 + 32'(i));
    end
    check("B bte", {30'd0, bte_seen}, 32'h2);
    check("B cti6", {29'd0, cti_log[6]}, 32'h2);
    check("B cti7", {29'd0, cti_log[7]}, 32'h7);
    check("B pops", pops, 8);
    check("B done count", done_n, 1);
    check("B no rdat", rd_log.size(), 0);

    // C: error on beat 2 of a 4-beat refill
    clear_rec(); use8 = 1'b0; req_adr = 32'h0; req_we = 1'b0; pend = 1; err_beat = 2;
    repeat (10) tick();
    check("C err count", err_n, 1);
    check("C err timing", err_seen_cyc, err_drv_cyc + 1);
    check("C no done", done_n, 0);
    check("C rdat count", rd_log.size(), 2);
    check("C cyc low after err", {31'd0, cyc_hist[err_drv_cyc + 1]}, 32'h0);

    // D: retry on beat 1, beat reissued at the same address after one idle cycle
    clear_rec(); use8 = 1'b0; req_adr = 32'h4; req_we = 1'b0; pend = 1; rty_beat = 1;
    repeat (14) tick();
    check("D rty adr", rty_adr, 32'h8);
    check("D reissue adr", adr_log[1], 32'h8);
    check("D acks", acks, 4);
    check("D gap", gaps(), 1);
    check("D cti3", {29'd0, cti_log[3]}, 32'h7);
    check("D rdat3", rd_log[3], 32'hD000_0000);
    check("D done count", done_n, 1);

    // E: back-to-back lines with valid held
    clear_rec(); use8 = 1'b0; req_adr = 32'h0; req_we = 1'b0; pend = 2;
    repeat (20) tick();
    check("E done count", done_n, 2);
    check("E gap", gaps(), 1);
    check("E acks", acks, 8);
    check("E rdat count", rd_log.size(), 8);

    // F: reset while beat 2 is on the bus, then a clean line
    clear_rec(); use8 = 1'b0; req_adr = 32'h8; req_we = 1'b0; pend = 1;
    for (int k = 0; k < 20 && acks < 2; k++) tick();
    check("F reached beat 2", acks, 2);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1; ack = 1'b0; err = 1'b0; rty = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    check_reset("F mid-burst rst");
    clear_rec(); pend = 1;
    repeat (12) tick();
    check("F done count", done_n, 1);
    check("F no err", err_n, 0);
    check("F rdat count", rd_log.size(), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
